// File: rtl/ptc_tag_manager.sv
// ptc_tag_manager
//   Round-robin read-request arbiter with PCIe tag allocation and completion
//   credit accounting. Each winning request gets the lowest free tag and
//   reserves L dwords of completion buffer. The tag's owner port is recorded
//   so that the completion router can look it up. Releases return credits
//   and, on the last completion, the tag.
// Ports
//   clk_i, rst_n_i           clock, async active-low reset
//   req_vld_i/req_len_i      per-port read request (len 0 = 2**LEN_WIDTH dwords)
//   req_rdy_o                per-port accept (one-hot or zero, combinational)
//   gnt_*_o / gnt_rdy_i      registered grant output (port, tag, raw length)
//   rel_*_i                  completion release (credits, tag free on last)
//   lkp_tag_i / lkp_port_o   owner lookup, one cycle latency
//   free_tags_o, credits_o   free tag count and free completion dwords
//   err_o                    sticky protocol error
module ptc_tag_manager #(
   parameter int DMA_PORTS      = 2,
   parameter int PCIE_TAG_WIDTH = 8,
   parameter int LEN_WIDTH      = 10,
   parameter int CPL_CREDITS    = 2048,
   localparam int CW    = $clog2(CPL_CREDITS + 1),
   localparam int PW    = (DMA_PORTS > 1) ? $clog2(DMA_PORTS) : 1,
   localparam int NTAGS = 2 ** PCIE_TAG_WIDTH
) (
   input  logic                                clk_i,
   input  logic                                rst_n_i,
   input  logic [DMA_PORTS-1:0]                req_vld_i,
   input  logic [DMA_PORTS-1:0][LEN_WIDTH-1:0] req_len_i,
   output logic [DMA_PORTS-1:0]                req_rdy_o,
   output logic                                gnt_vld_o,
   output logic [PW-1:0]                       gnt_port_o,
   output logic [PCIE_TAG_WIDTH-1:0]           gnt_tag_o,
   output logic [LEN_WIDTH-1:0]                gnt_len_o,
   input  logic                                gnt_rdy_i,
   input  logic                                rel_vld_i,
   input  logic [PCIE_TAG_WIDTH-1:0]           rel_tag_i,
   input  logic [LEN_WIDTH:0]                  rel_len_i,
   input  logic                                rel_last_i,
   input  logic [PCIE_TAG_WIDTH-1:0]           lkp_tag_i,
   output logic [PW-1:0]                       lkp_port_o,
   output logic [PCIE_TAG_WIDTH:0]             free_tags_o,
   output logic [CW-1:0]                       credits_o,
   output logic                                err_o
);

   // Common width for credit arithmetic; one spare bit so credits + release
   // cannot wrap before the saturation compare.
   localparam int SW = ((CW > LEN_WIDTH + 1) ? CW : LEN_WIDTH + 1) + 1;

   logic [NTAGS-1:0]           tag_free_q, tag_free_d;
   logic [PW-1:0]              owner_q [NTAGS];
   logic [PCIE_TAG_WIDTH:0]    free_q, free_d;
   logic [CW-1:0]              credits_q, credits_d;
   logic [PW-1:0]              rr_q, rr_d;
   logic                       gnt_vld_q;
   logic [PW-1:0]              gnt_port_q, lkp_q;
   logic [PCIE_TAG_WIDTH-1:0]  gnt_tag_q;
   logic [LEN_WIDTH-1:0]       gnt_len_q;
   logic                       err_q, err_d;

   logic [DMA_PORTS-1:0]       elig;
   logic                       win;
   logic [PW-1:0]              win_idx;
   logic [PCIE_TAG_WIDTH-1:0]  alloc_tag;
   logic [LEN_WIDTH:0]         win_len;
   logic [SW-1:0]              sum;
   logic                       sat, rel_free, rel_dup;
   int                         idx;

   function automatic logic [LEN_WIDTH:0] eff_len(input logic [LEN_WIDTH-1:0] len);
      return (len == '0) ? {1'b1, {LEN_WIDTH{1'b0}}} : {1'b0, len};
   endfunction

   always_comb begin
      elig      = '0;
      win       = 1'b0;
      win_idx   = '0;
      idx       = 0;
      req_rdy_o = '0;
      alloc_tag = '0;
      // Held in reset, nothing is accepted even though the state looks idle.
      for (int p = 0; p < DMA_PORTS; p++)
         elig[p] = rst_n_i && req_vld_i[p] && (|tag_free_q) && (!gnt_vld_q || gnt_rdy_i) &&
                   (SW'(eff_len(req_len_i[p])) <= SW'(credits_q));
      for (int o = 0; o < DMA_PORTS; o++) begin
         idx = int'(rr_q) + o;
         if (idx >= DMA_PORTS) idx = idx - DMA_PORTS;
         if (!win && elig[idx]) begin
            win     = 1'b1;
            win_idx = PW'(idx);
         end
      end
      if (win) req_rdy_o[win_idx] = 1'b1;
      rr_d = rr_q;
      if (win) rr_d = (int'(win_idx) == DMA_PORTS - 1) ? '0 : win_idx + PW'(1);

      // Lowest free tag wins: scan downward so the last hit is the lowest.
      for (int t = NTAGS - 1; t >= 0; t--)
         if (tag_free_q[t]) alloc_tag = PCIE_TAG_WIDTH'(t);

      win_len   = eff_len(req_len_i[win_idx]);
      sum       = SW'(credits_q) - (win ? SW'(win_len) : '0) + (rel_vld_i ? SW'(rel_len_i) : '0);
      sat       = sum > SW'(CPL_CREDITS);
      credits_d = sat ? CW'(CPL_CREDITS) : sum[CW-1:0];

      // A tag released this cycle is set in _d only, so it cannot be picked
      // by the encoder (which reads _q) until the next cycle.
      rel_free   = rel_vld_i && rel_last_i && !tag_free_q[rel_tag_i];
      rel_dup    = rel_vld_i && rel_last_i &&  tag_free_q[rel_tag_i];
      tag_free_d = tag_free_q;
      if (rel_free) tag_free_d[rel_tag_i] = 1'b1;
      if (win)      tag_free_d[alloc_tag] = 1'b0;
      free_d = free_q - (PCIE_TAG_WIDTH + 1)'(win) + (PCIE_TAG_WIDTH + 1)'(rel_free);
      err_d  = err_q | rel_dup | sat;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tag_free_q <= '1;
         free_q     <= (PCIE_TAG_WIDTH + 1)'(NTAGS);
         credits_q  <= CW'(CPL_CREDITS);
         rr_q       <= '0;
         gnt_vld_q  <= 1'b0;
         gnt_port_q <= '0;
         gnt_tag_q  <= '0;
         gnt_len_q  <= '0;
         lkp_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         tag_free_q <= tag_free_d;
         free_q     <= free_d;
         credits_q  <= credits_d;
         rr_q       <= rr_d;
         err_q      <= err_d;
         lkp_q      <= owner_q[lkp_tag_i];
         if (win) begin
            gnt_vld_q  <= 1'b1;
            gnt_port_q <= win_idx;
            gnt_tag_q  <= alloc_tag;
            gnt_len_q  <= req_len_i[win_idx];
         end else if (gnt_rdy_i) begin
            gnt_vld_q  <= 1'b0;
         end
      end
   end

   // Owner RAM: no reset, entries are only meaningful for allocated tags.
   always_ff @(posedge clk_i)
      if (win) owner_q[alloc_tag] <= win_idx;

   assign gnt_vld_o   = gnt_vld_q;
   assign gnt_port_o  = gnt_port_q;
   assign gnt_tag_o   = gnt_tag_q;
   assign gnt_len_o   = gnt_len_q;
   assign lkp_port_o  = lkp_q;
   assign free_tags_o = free_q;
   assign credits_o   = credits_q;
   assign err_o       = err_q;

endmodule
